// File: rtl/array_refresh_burst.sv
// array_refresh_burst: multi-bank burst refresh sequencer.
// One start request issues a configurable number of row activations
// (ACT -> tRAS with selected banks' cs_n low -> tRP precharge) to the
// banks in the latched mask. The row pointer persists across bursts and
// wraps at the latched row limit.
// Optional feature macro: ARRAY_RF_ABORT_EN adds array_rf_abort and
// array_rf_aborted for early burst termination.
module array_refresh_burst #(
    parameter int ARRAY_ROW_ADDR_WIDTH = 16,
    parameter int NUM_BANKS            = 4,
    parameter int RF_ROWS_WIDTH        = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            array_rf_start,
    input  logic [RF_ROWS_WIDTH-1:0]        array_rf_rows,
    input  logic [NUM_BANKS-1:0]            array_rf_bank_mask,
    input  logic [ARRAY_ROW_ADDR_WIDTH-1:0] array_row_max,
    input  logic [7:0]                      array_tRAS,
    input  logic [7:0]                      array_tRP,
`ifdef ARRAY_RF_ABORT_EN
    input  logic                            array_rf_abort,
    output logic                            array_rf_aborted,
`endif
    output logic                            array_rf_busy,
    output logic                            array_rf_done,
    output logic [NUM_BANKS-1:0]            array_cs_n,
    output logic [ARRAY_ROW_ADDR_WIDTH-1:0] array_raddr
);

    localparam int W = ARRAY_ROW_ADDR_WIDTH;
    localparam logic [W-1:0]             PTR_ONE  = 1;
    localparam logic [RF_ROWS_WIDTH-1:0] ROWS_ONE = 1;

    typedef enum logic [2:0] {IDLE, ACT, TRAS, TRP, DONE} state_t;

    state_t                   state;
    logic [RF_ROWS_WIDTH-1:0] rows_left;
    logic [NUM_BANKS-1:0]     mask_q;
    logic [W-1:0]             row_max_q;
    logic [7:0]               tras_m1;   // tRAS_eff - 1
    logic [7:0]               trp_m1;    // tRP_eff - 1
    logic [7:0]               cnt;       // shared tRAS / tRP down-counter
    logic [W-1:0]             row_ptr;
    logic [W-1:0]             row_ptr_nxt;
    logic                     stop_now;  // end burst after the current row
`ifdef ARRAY_RF_ABORT_EN
    logic                     abort_pend;
`endif

    // Pointer advance: wrap at the latched limit; if the limit was lowered
    // below the pointer, plain increment wraps naturally at 2^W.
    assign row_ptr_nxt = (row_ptr == row_max_q) ? '0 : row_ptr + PTR_ONE;
    assign array_raddr = row_ptr;

`ifdef ARRAY_RF_ABORT_EN
    assign stop_now = abort_pend | array_rf_abort;
`else
    assign stop_now = 1'b0;
`endif

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rows_left     <= '0;
            mask_q        <= '0;
            row_max_q     <= '0;
            tras_m1       <= '0;
            trp_m1        <= '0;
            cnt           <= '0;
            row_ptr       <= '0;
            array_rf_busy <= 1'b0;
            array_rf_done <= 1'b0;
            array_cs_n    <= '1;
`ifdef ARRAY_RF_ABORT_EN
            abort_pend       <= 1'b0;
            array_rf_aborted <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    array_rf_busy <= 1'b0;
                    array_rf_done <= 1'b0;
                    array_cs_n    <= '1;
                    if (array_rf_start) begin
                        rows_left     <= array_rf_rows;
                        mask_q        <= array_rf_bank_mask;
                        row_max_q     <= array_row_max;
                        tras_m1       <= (array_tRAS == 8'd0) ? 8'd0 : array_tRAS - 8'd1;
                        trp_m1        <= (array_tRP  == 8'd0) ? 8'd0 : array_tRP  - 8'd1;
                        array_rf_busy <= 1'b1;
`ifdef ARRAY_RF_ABORT_EN
                        abort_pend    <= 1'b0;
`endif
                        // Empty burst: no activation, pointer untouched.
                        if (array_rf_rows == '0 || array_rf_bank_mask == '0) begin
                            state         <= DONE;
                            array_rf_done <= 1'b1;
                        end else begin
                            state <= ACT;
                        end
                    end
                end

                ACT: begin
`ifdef ARRAY_RF_ABORT_EN
                    if (array_rf_abort) begin
                        state            <= DONE;
                        array_rf_done    <= 1'b1;
                        array_rf_aborted <= 1'b1;
                    end else
`endif
                    begin
                        array_cs_n <= ~mask_q;
                        cnt        <= tras_m1;
                        state      <= TRAS;
                    end
                end

                TRAS: begin
`ifdef ARRAY_RF_ABORT_EN
                    if (array_rf_abort) abort_pend <= 1'b1;
`endif
                    if (cnt == 8'd0) begin
                        // Address moves only here, with cs_n going high.
                        array_cs_n <= '1;
                        cnt        <= trp_m1;
                        rows_left  <= rows_left - ROWS_ONE;
                        row_ptr    <= row_ptr_nxt;
                        state      <= TRP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                TRP: begin
`ifdef ARRAY_RF_ABORT_EN
                    if (array_rf_abort) abort_pend <= 1'b1;
`endif
                    if (cnt == 8'd0) begin
                        if (rows_left == '0 || stop_now) begin
                            state         <= DONE;
                            array_rf_done <= 1'b1;
`ifdef ARRAY_RF_ABORT_EN
                            // Early end only if rows were actually skipped.
                            array_rf_aborted <= (rows_left != '0);
`endif
                        end else begin
                            state <= ACT;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                DONE: begin
                    array_rf_done <= 1'b0;
                    array_rf_busy <= 1'b0;
`ifdef ARRAY_RF_ABORT_EN
                    array_rf_aborted <= 1'b0;
                    abort_pend       <= 1'b0;
`endif
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
